// File: rtl/ariane_pkg.sv
// Shared types for the pipelined integer ALU: operator encoding, issue record
// and the per-stage pipeline record.
package ariane_pkg;
  localparam int unsigned XLEN           = 64;
  localparam int unsigned TRANS_ID_BITS  = 4;
  localparam int unsigned ALU_MAX_STAGES = 3;

  typedef enum logic [6:0] {
    ADD, SUB, ADDW, SUBW, XORL, ORL, ANDL,
    SRA, SRL, SLL, SRLW, SLLW, SRAW,
    LTS, LTU, GES, GEU, EQ, NE, SLTS, SLTU,
    ROL, ROR, ROLW, RORW
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic                     valid;
    logic [XLEN-1:0]          result;
    logic                     branch;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } alu_stage_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
endpackage

// File: rtl/alu_pipe_datapath.sv
// Combinational ALU core: operator + operands -> result and branch outcome.
// Rotate hardware exists only when EnableRot is set.
module alu_datapath
  import ariane_pkg::*;
#(
  parameter bit EnableRot = 1'b1
) (
  input  fu_op            operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] result,
  output logic            branch
);
  logic            negate, sgn, less, adder_z;
  logic [XLEN:0]   adder_a, adder_b, adder_sum;
  logic [XLEN-1:0] adder_res, sra_res, rot_res;
  logic [31:0]     sraw_res;
  logic            unused_lsb;

  // Carry-in rides in bit 0 so a single adder serves add, sub and equality.
  assign negate     = operation inside {SUB, SUBW, EQ, NE};
  assign adder_a    = {operand_a, 1'b1};
  assign adder_b    = {operand_b, 1'b0} ^ {(XLEN+1){negate}};
  assign adder_sum  = adder_a + adder_b;
  assign adder_res  = adder_sum[XLEN:1];
  assign unused_lsb = adder_sum[0];
  assign adder_z    = ~|adder_res;

  assign sgn  = operation inside {LTS, GES, SLTS};
  assign less = sgn ? ($signed(operand_a) < $signed(operand_b)) : (operand_a < operand_b);

  assign sra_res  = $unsigned($signed(operand_a) >>> operand_b[5:0]);
  assign sraw_res = $unsigned($signed(operand_a[31:0]) >>> operand_b[4:0]);

  if (EnableRot) begin : g_rot
    logic [XLEN-1:0] rol64, ror64;
    logic [31:0]     rol32, ror32;
    // A shift by the full width yields zero, which covers the zero-amount case.
    assign rol64 = (operand_a << operand_b[5:0]) | (operand_a >> (7'd64 - {1'b0, operand_b[5:0]}));
    assign ror64 = (operand_a >> operand_b[5:0]) | (operand_a << (7'd64 - {1'b0, operand_b[5:0]}));
    assign rol32 = (operand_a[31:0] << operand_b[4:0]) |
                   (operand_a[31:0] >> (6'd32 - {1'b0, operand_b[4:0]}));
    assign ror32 = (operand_a[31:0] >> operand_b[4:0]) |
                   (operand_a[31:0] << (6'd32 - {1'b0, operand_b[4:0]}));
    always_comb begin
      rot_res = '0;
      case (operation)
        ROL:     rot_res = rol64;
        ROR:     rot_res = ror64;
        ROLW:    rot_res = sext32(rol32);
        RORW:    rot_res = sext32(ror32);
        default: rot_res = '0;
      endcase
    end
  end else begin : g_no_rot
    assign rot_res = '0;
  end

  always_comb begin
    result = '0;
    branch = 1'b1;
    case (operation)
      ADD, SUB:               result = adder_res;
      ADDW, SUBW:             result = sext32(adder_res[31:0]);
      XORL:                   result = operand_a ^ operand_b;
      ORL:                    result = operand_a | operand_b;
      ANDL:                   result = operand_a & operand_b;
      SLL:                    result = operand_a << operand_b[5:0];
      SRL:                    result = operand_a >> operand_b[5:0];
      SRA:                    result = sra_res;
      SLLW:                   result = sext32(operand_a[31:0] << operand_b[4:0]);
      SRLW:                   result = sext32(operand_a[31:0] >> operand_b[4:0]);
      SRAW:                   result = sext32(sraw_res);
      SLTS, SLTU:             result = {{(XLEN-1){1'b0}}, less};
      EQ:                     branch = adder_z;
      NE:                     branch = ~adder_z;
      LTS, LTU:               branch = less;
      GES, GEU:               branch = ~less;
      ROL, ROR, ROLW, RORW:   result = rot_res;
      default:                ;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational datapath followed by NrStages elastic stage
// registers with a ready chain for back-pressure and a global flush.
module alu_pipe
  import ariane_pkg::*;
#(
  parameter int unsigned NrStages  = 1,
  parameter bit          EnableRot = 1'b1,
  parameter int unsigned TransIdW  = TRANS_ID_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  fu_data_t            fu_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     result_o,
  output logic                branch_res_o,
  output logic [TransIdW-1:0] trans_id_o
);
  if (NrStages < 1 || NrStages > ALU_MAX_STAGES) begin : g_bad_stages
    $error("alu_pipe: NrStages must be within 1..ALU_MAX_STAGES");
  end
  if (TransIdW < 1 || TransIdW > TRANS_ID_BITS) begin : g_bad_tid
    $error("alu_pipe: TransIdW must be within 1..TRANS_ID_BITS");
  end

  logic [XLEN-1:0]   dp_result;
  logic              dp_branch;
  logic [XLEN-1:0]   unused_imm;
  alu_stage_t        stage_q  [NrStages];
  alu_stage_t        stage_in [NrStages];
  logic [NrStages:0] advance;

  assign unused_imm = fu_data_i.imm;

  alu_datapath #(.EnableRot(EnableRot)) i_datapath (
    .operation (fu_data_i.operation),
    .operand_a (fu_data_i.operand_a),
    .operand_b (fu_data_i.operand_b),
    .result    (dp_result),
    .branch    (dp_branch)
  );

  // The consumer's ready acts as the advance of a virtual stage past the end.
  assign advance[NrStages] = ready_i;
  assign stage_in[0]       = {valid_i & ~flush_i, dp_result, dp_branch, fu_data_i.trans_id};

  for (genvar k = 0; k < NrStages; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_in[k] = stage_q[k-1];
    end
    assign advance[k] = ~stage_q[k].valid | advance[k+1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q[k] <= '0;
      end else if (flush_i) begin
        stage_q[k].valid <= 1'b0;
      end else if (advance[k]) begin
        stage_q[k].valid <= stage_in[k].valid;
        // Payload only moves with a real op; bubbles leave it stale.
        if (stage_in[k].valid) begin
          stage_q[k].result   <= stage_in[k].result;
          stage_q[k].branch   <= stage_in[k].branch;
          stage_q[k].trans_id <= stage_in[k].trans_id;
        end
      end
    end
  end

  assign ready_o      = advance[0];
  assign valid_o      = stage_q[NrStages-1].valid;
  assign result_o     = stage_q[NrStages-1].result;
  assign branch_res_o = stage_q[NrStages-1].branch;
  assign trans_id_o   = stage_q[NrStages-1].trans_id[TransIdW-1:0];
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 3-stage rotate build and a 2-stage no-rotate build
// share stimulus and are checked every cycle against a timing/value model.
module tb_alu_pipe;
  import ariane_pkg::*;

  logic clk, rst_n, flush, ready_i, v3, v2;
  fu_data_t fu;
  logic rdy3, rdy2, vo3, vo2, br3, br2;
  logic [63:0] res3, res2;
  logic [3:0] id3, id2;

  alu_pipe #(.NrStages(3), .EnableRot(1'b1), .TransIdW(4)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(v3), .ready_o(rdy3),
    .fu_data_i(fu), .valid_o(vo3), .ready_i(ready_i), .result_o(res3),
    .branch_res_o(br3), .trans_id_o(id3));

  alu_pipe #(.NrStages(2), .EnableRot(1'b0), .TransIdW(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(v2), .ready_o(rdy2),
    .fu_data_i(fu), .valid_o(vo2), .ready_i(ready_i), .result_o(res2),
    .branch_res_o(br2), .trans_id_o(id2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [63:0] res;
    logic        br;
    logic [3:0]  id;
    int          t;
    bit          lit;
    logic [63:0] lres;
    logic        lbr;
  } rec_t;

  rec_t        mq [2][64];
  int          hd [2];
  int          tl [2];
  int          last_leave [2];
  int          out_cnt [2];
  int          ncyc;
  int          total, bad;
  bit          cur_lit;
  logic [63:0] cur_lres;
  logic        cur_lbr;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, k, ncyc, act, exp);
    end
  endtask

  // Reference ALU from the operator definitions; rotates done bit by bit.
  function automatic void model(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                                input bit rot, output logic [63:0] r, output logic br);
    logic [31:0] w;
    int s;
    r  = '0;
    br = 1'b1;
    w  = '0;
    case (op)
      ADD:  r = a + b;
      SUB:  r = a - b;
      ADDW: r = sext32(a[31:0] + b[31:0]);
      SUBW: r = sext32(a[31:0] - b[31:0]);
      XORL: r = a ^ b;
      ORL:  r = a | b;
      ANDL: r = a & b;
      SLL:  r = a << b[5:0];
      SRL:  r = a >> b[5:0];
      SRA:  r = $signed(a) >>> b[5:0];
      SLLW: r = sext32(a[31:0] << b[4:0]);
      SRLW: r = sext32(a[31:0] >> b[4:0]);
      SRAW: r = sext32($signed(a[31:0]) >>> b[4:0]);
      SLTS: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      SLTU: r = (a < b) ? 64'd1 : 64'd0;
      EQ:   br = (a == b);
      NE:   br = (a != b);
      LTS:  br = ($signed(a) < $signed(b));
      LTU:  br = (a < b);
      GES:  br = ($signed(a) >= $signed(b));
      GEU:  br = (a >= b);
      ROL: if (rot) begin
        s = int'(b[5:0]);
        for (int i = 0; i < 64; i++) r[(i + s) % 64] = a[i];
      end
      ROR: if (rot) begin
        s = int'(b[5:0]);
        for (int i = 0; i < 64; i++) r[i] = a[(i + s) % 64];
      end
      ROLW: if (rot) begin
        s = int'(b[4:0]);
        for (int i = 0; i < 32; i++) w[(i + s) % 32] = a[i];
        r = sext32(w);
      end
      RORW: if (rot) begin
        s = int'(b[4:0]);
        for (int i = 0; i < 32; i++) w[i] = a[(i + s) % 32];
        r = sext32(w);
      end
      default: ;
    endcase
  endfunction

  // One model step per instance per cycle: check outputs, then apply the
  // handshakes/flush/accept that the coming clock edge will perform.
  task automatic step(input int k, input int n_st, input logic vo, input logic ro,
                      input logic [63:0] res, input logic br, input logic [3:0] id,
                      input logic vin);
    int cnt, rt;
    bit vis, exp_rdy;
    rec_t h, n;
    logic [63:0] mr;
    logic mb;
    cnt = tl[k] - hd[k];
    if (!rst_n) begin
      chk("rst_valid", k, {63'd0, vo}, 64'd0);
      chk("rst_result", k, res, 64'd0);
      chk("rst_branch", k, {63'd0, br}, 64'd0);
      chk("rst_id", k, {60'd0, id}, 64'd0);
      chk("rst_ready", k, {63'd0, ro}, 64'd1);
      hd[k] = 0; tl[k] = 0; last_leave[k] = -100;
      return;
    end
    vis = 1'b0;
    h   = '0;
    if (cnt > 0) begin
      h  = mq[k][hd[k] % 64];
      rt = h.t + n_st;
      if (last_leave[k] + 1 > rt) rt = last_leave[k] + 1;
      vis = (ncyc >= rt);
    end
    exp_rdy = !(cnt == n_st && !ready_i);
    chk("ready", k, {63'd0, ro}, {63'd0, exp_rdy});
    chk("valid", k, {63'd0, vo}, {63'd0, vis});
    if (vis) begin
      chk("result", k, res, h.res);
      chk("branch", k, {63'd0, br}, {63'd0, h.br});
      chk("trans_id", k, {60'd0, id}, {60'd0, h.id});
      if (h.lit) begin
        chk("lit_result", k, res, h.lres);
        chk("lit_branch", k, {63'd0, br}, {63'd0, h.lbr});
      end
    end
    if (vis && ready_i) begin
      hd[k]++;
      last_leave[k] = ncyc;
      out_cnt[k]++;
    end
    if (flush) begin
      hd[k] = tl[k];
      last_leave[k] = -100;
    end else if (vin && exp_rdy) begin
      model(fu.operation, fu.operand_a, fu.operand_b, (k == 0), mr, mb);
      n.res = mr; n.br = mb; n.id = fu.trans_id; n.t = ncyc;
      n.lit = cur_lit; n.lres = cur_lres; n.lbr = cur_lbr;
      if (k == 1 && (fu.operation inside {ROL, ROR, ROLW, RORW})) begin
        n.lres = '0;
        n.lbr  = 1'b1;
      end
      mq[k][tl[k] % 64] = n;
      tl[k]++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      step(0, 3, vo3, rdy3, res3, br3, id3, v3);
      step(1, 2, vo2, rdy2, res2, br2, id2, v2);
    end
  end

  task automatic set_op(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] id, input bit lit, input logic [63:0] lr, input logic lb);
    fu.operation = op;
    fu.operand_a = a;
    fu.operand_b = b;
    fu.imm       = '0;
    fu.trans_id  = id;
    cur_lit  = lit;
    cur_lres = lr;
    cur_lbr  = lb;
  endtask

  // Present an op until each instance has taken it once.
  task automatic send(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] id, input bit lit, input logic [63:0] lr, input logic lb);
    logic r3, r2;
    set_op(op, a, b, id, lit, lr, lb);
    v3 = 1'b1;
    v2 = 1'b1;
    for (int c = 0; c < 40 && (v3 || v2); c++) begin
      @(negedge clk);
      r3 = rdy3;
      r2 = rdy2;
      @(posedge clk);
      #1;
      if (r3) v3 = 1'b0;
      if (r2) v2 = 1'b0;
    end
    if (v3 || v2) begin
      total++;
      bad++;
      $display("FAIL send_timeout id=%0d v3=%0b v2=%0b", id, v3, v2);
      v3 = 1'b0;
      v2 = 1'b0;
    end
    cur_lit = 1'b0;
  endtask

  // Present an op for exactly one cycle, taken or not.
  task automatic pulse(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] id, input logic fl);
    set_op(op, a, b, id, 1'b0, '0, 1'b0);
    v3 = 1'b1;
    v2 = 1'b1;
    flush = fl;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    v2 = 1'b0;
    flush = 1'b0;
  endtask

  bit low_seen;
  int base_out;

  initial begin
    total = 0; bad = 0; ncyc = 0;
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; last_leave[k] = -100; out_cnt[k] = 0;
    end
    cur_lit = 1'b0; cur_lres = '0; cur_lbr = 1'b0;
    rst_n = 1'b0; flush = 1'b0; ready_i = 1'b1; v3 = 1'b0; v2 = 1'b0; fu = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency on the 2-stage build.
    send(ADD, 64'd5, 64'd7, 4'd3, 1'b1, 64'd12, 1'b1);
    @(negedge clk);
    chk("lat_early_valid", 1, {63'd0, vo2}, 64'd0);
    @(negedge clk);
    chk("lat_valid", 1, {63'd0, vo2}, 64'd1);
    chk("lat_result", 1, res2, 64'd12);
    chk("lat_id", 1, {60'd0, id2}, 64'd3);
    @(posedge clk); #1;

    // Directed corners with hand-computed results.
    send(ADDW, 64'h7FFF_FFFF, 64'd1, 4'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    send(SRA, 64'h8000_0000_0000_0000, 64'd63, 4'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd3, 1'b1, 64'd0, 1'b1);
    send(EQ, 64'd9, 64'd9, 4'd4, 1'b1, 64'd0, 1'b1);
    send(LTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd5, 1'b1, 64'd0, 1'b1);
    send(LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd6, 1'b1, 64'd0, 1'b0);
    send(ROR, 64'd1, 64'd1, 4'd7, 1'b1, 64'h8000_0000_0000_0000, 1'b1);
    send(RORW, 64'd1, 64'd1, 4'd8, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1);
    send(ROL, 64'h8000_0000_0000_0001, 64'd4, 4'd9, 1'b1, 64'h18, 1'b1);
    send(SUB, 64'd3, 64'd5, 4'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send(SRLW, 64'hFFFF_FFFF_8000_0000, 64'd4, 4'd11, 1'b1, 64'h0000_0000_0800_0000, 1'b1);
    send(fu_op'(7'h7F), 64'd5, 64'd5, 4'd12, 1'b1, 64'd0, 1'b1);
    send(GEU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd13, 1'b1, 64'd0, 1'b0);
    send(NE, 64'd1, 64'd2, 4'd14, 1'b1, 64'd0, 1'b1);
    send(SLTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd15, 1'b1, 64'd1, 1'b1);
    repeat (6) @(posedge clk); #1;

    // Back-pressure: stall the consumer mid-stream.
    base_out = out_cnt[0];
    low_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(ADD, 64'(i), 64'd100, 4'(i), 1'b1, 64'(100 + i), 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!rdy3) low_seen = 1'b1;
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    chk("bp_ready_low", 0, {63'd0, low_seen}, 64'd1);
    chk("bp_out_count", 0, 64'(out_cnt[0] - base_out), 64'd10);
    chk("bp_drained", 0, 64'(tl[0] - hd[0]), 64'd0);

    // Flush with ops in flight and a new op on the input.
    ready_i = 1'b0;
    pulse(XORL, 64'hF0, 64'h0F, 4'd1, 1'b0);
    pulse(ORL, 64'hF0, 64'h0F, 4'd2, 1'b0);
    pulse(ANDL, 64'hF0, 64'hFF, 4'd3, 1'b0);
    pulse(ADD, 64'd1, 64'd1, 4'd4, 1'b1);
    @(negedge clk);
    chk("flush_valid3", 0, {63'd0, vo3}, 64'd0);
    chk("flush_valid2", 1, {63'd0, vo2}, 64'd0);
    @(posedge clk); #1;
    ready_i = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Asynchronous reset pulse mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(SLL, 64'd1, 64'(i), 4'(i), 1'b1, 64'd1 << i, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid3", 0, {63'd0, vo3}, 64'd0);
        chk("midrst_result3", 0, res3, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    chk("end_empty3", 0, 64'(tl[0] - hd[0]), 64'd0);
    chk("end_empty2", 1, 64'(tl[1] - hd[1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
